fetch_redirect_unit: RTL

Fetch-stage controller that consumes the execute-stage branch/jump decision (`PCSrc`, `PCTargetE`) and acts on it. It owns the program counter, issues instruction-memory fetches over a single-outstanding valid/ready interface, and presents fetched instructions to the F/D boundary. On a taken redirect it raises flush to the D and E stages and discards any wrong-path fetch still in flight.

---
 rtl/fetch_redirect_unit_pkg.sv | 16 +
 rtl/fetch_redirect_unit_skid.sv | 30 +++
 rtl/fetch_redirect_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP encoding, default width.
package fetch_redirect_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_unit_skid.sv
// One-entry holding register for a fetched instruction and its PC.
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch controller: owns the PC, issues single-outstanding imem requests,
// and squashes wrong-path fetches on an execute-stage redirect.
module fetch_redirect_unit #(
    parameter int              XLEN     = fetch_redirect_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            InstrValidF,
    output logic            FlushD,
    output logic            FlushE
);

    import fetch_redirect_unit_pkg::*;

    localparam logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pend_pc;
    logic [XLEN-1:0] instr_q, pc_q, pc4_q;
    logic            valid_q;

    logic            req_valid, fire;
    logic            skid_load, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_instr, skid_pc;

    logic            out_load, out_valid;
    logic [XLEN-1:0] out_instr, out_pc;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_instr (imem_rsp_data),
        .in_pc    (pend_pc),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // A response coinciding with a redirect must not launch a new request
    always_comb begin
        req_valid = 1'b0;
        unique case (state)
            S_REQ:   req_valid = !StallF;
            S_WAIT:  req_valid = imem_rsp_valid && !StallF && !PCSrc;
            default: req_valid = 1'b0;
        endcase
    end

    assign fire = req_valid && imem_req_ready;

    always_comb begin
        state_nxt  = state;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        out_load   = !StallF || PCSrc;
        out_valid  = 1'b0;
        out_instr  = NOP;
        out_pc     = pc_q;
        unique case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (fire)
                    state_nxt = PCSrc ? S_DROP : S_WAIT;
                else
                    state_nxt = S_REQ;
            end
            S_WAIT: begin
                if (PCSrc) begin
                    state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (StallF) begin
                        state_nxt = S_HOLD;
                        skid_load = 1'b1;
                    end else begin
                        state_nxt = fire ? S_WAIT : S_REQ;
                        out_valid = 1'b1;
                        out_instr = imem_rsp_data;
                        out_pc    = pend_pc;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrc) begin
                    state_nxt  = S_REQ;
                end else if (!StallF) begin
                    state_nxt  = S_REQ;
                    skid_clear = 1'b1;
                    out_valid  = skid_valid;
                    out_instr  = skid_valid ? skid_instr : NOP;
                    out_pc     = skid_valid ? skid_pc : pc_q;
                end
            end
            S_DROP: begin
                // Wrong-path response retires here; no further one is owed
                if (imem_rsp_valid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (PCSrc) begin
            skid_clear = 1'b1;
            out_valid  = 1'b0;
            out_instr  = NOP;
            out_pc     = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (PCSrc)
                pc <= {PCTargetE[XLEN-1:2], 2'b00};
            else if (fire)
                pc <= pc + FOUR;
            if (fire)
                pend_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + FOUR;
            valid_q <= 1'b0;
        end else if (out_load) begin
            instr_q <= out_instr;
            pc_q    <= out_pc;
            pc4_q   <= out_pc + FOUR;
            valid_q <= out_valid;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc;
    assign InstrF         = instr_q;
    assign PCF            = pc_q;
    assign PCPlus4F       = pc4_q;
    assign InstrValidF    = valid_q;
    assign FlushD         = PCSrc;
    assign FlushE         = PCSrc;

endmodule
